// File: rtl/q100_dtcm_arb.sv
// q100_dtcm_arb
//   Shares one single-port DTCM SRAM between the core data port and a
//   host/loader port. Grants are same-cycle and combinational. The core wins
//   contention until the host has been refused HOST_MAX_WAIT cycles in a row;
//   then the host is forced through. Read data is steered back to the port
//   that issued the read, RD_LATENCY cycles later, in issue order.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   core_req/we/addr/wdata_i  core request (we all-zero = read)
//   core_gnt_o                core request accepted this cycle
//   core_rvalid/rdata_o       core read response
//   host_*                    same set for the host/loader port
//   mem_en/we/addr/wdata_o    SRAM request side
//   mem_rdata_i               SRAM read data, RD_LATENCY cycles after a read
//   wait_cnt_o                consecutive refused host-request cycles (debug)
module q100_dtcm_arb #(
  parameter int DTCM_ADDR_WIDTH = 12,
  parameter int DTCM_DATA_WIDTH = 32,
  parameter int DTCM_BANK       = DTCM_DATA_WIDTH / 8,
  parameter int RD_LATENCY      = 1,
  parameter int HOST_MAX_WAIT   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_req_i,
  input  logic [DTCM_BANK-1:0]       core_we_i,
  input  logic [DTCM_ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DTCM_DATA_WIDTH-1:0] core_wdata_i,
  output logic                       core_gnt_o,
  output logic                       core_rvalid_o,
  output logic [DTCM_DATA_WIDTH-1:0] core_rdata_o,
  input  logic                       host_req_i,
  input  logic [DTCM_BANK-1:0]       host_we_i,
  input  logic [DTCM_ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DTCM_DATA_WIDTH-1:0] host_wdata_i,
  output logic                       host_gnt_o,
  output logic                       host_rvalid_o,
  output logic [DTCM_DATA_WIDTH-1:0] host_rdata_o,
  output logic                       mem_en_o,
  output logic [DTCM_BANK-1:0]       mem_we_o,
  output logic [DTCM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DTCM_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DTCM_DATA_WIDTH-1:0] mem_rdata_i,
  output logic [7:0]                 wait_cnt_o
);

  localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

  logic [7:0]                 wait_q;
  logic                       host_force;
  logic                       rd_issue;
  logic [RD_LATENCY-1:0]      vld_q;
  logic [RD_LATENCY-1:0]      own_q;   // 1 = response belongs to host
  logic                       rsp_vld;
  logic                       rsp_host;
  logic [DTCM_DATA_WIDTH-1:0] core_rdata_q;
  logic [DTCM_DATA_WIDTH-1:0] host_rdata_q;

  assign host_force = (wait_q == MAX_WAIT);

  // Grants are gated by rst so nothing reaches the SRAM while in reset.
  assign core_gnt_o = rst & core_req_i & ~(host_req_i & host_force);
  assign host_gnt_o = rst & host_req_i & (~core_req_i | host_force);

  assign mem_en_o    = core_gnt_o | host_gnt_o;
  assign mem_we_o    = host_gnt_o ? host_we_i :
                       core_gnt_o ? core_we_i : '0;
  assign mem_addr_o  = host_gnt_o ? host_addr_i  : core_addr_i;
  assign mem_wdata_o = host_gnt_o ? host_wdata_i : core_wdata_i;

  assign rd_issue = mem_en_o & ~(|mem_we_o);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else if (!host_req_i || host_gnt_o) begin
      wait_q <= '0;
    end else if (wait_q < MAX_WAIT) begin
      wait_q <= wait_q + 8'd1;
    end
  end

  // Response pipeline: one {valid, owner} slot per cycle of SRAM latency,
  // so mixed-owner reads come back in order at full throughput.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= rd_issue;
      own_q[0] <= host_gnt_o;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign rsp_vld  = vld_q[RD_LATENCY-1];
  assign rsp_host = own_q[RD_LATENCY-1];

  assign core_rvalid_o = rsp_vld & ~rsp_host;
  assign host_rvalid_o = rsp_vld &  rsp_host;

  // Returned data passes straight through on the response cycle and is
  // captured so each port's rdata holds its last value between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      if (core_rvalid_o) core_rdata_q <= mem_rdata_i;
      if (host_rvalid_o) host_rdata_q <= mem_rdata_i;
    end
  end

  assign core_rdata_o = core_rvalid_o ? mem_rdata_i : core_rdata_q;
  assign host_rdata_o = host_rvalid_o ? mem_rdata_i : host_rdata_q;

  assign wait_cnt_o = wait_q;

endmodule
